// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, size helpers and round constants for the AES key schedule
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_e;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int words_of(input int nk);
        return 4 * (nk + 7);
    endfunction

    // Number of Nk-word expansion steps needed to cover the whole schedule
    function automatic int steps_of(input int nk);
        return (words_of(nk) - nk + nk - 1) / nk;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_key_expansion.sv
// rtl/aes_key_schedule_ctrl_key_expansion.sv - one combinational key expansion step: Nk window words in, Nk new words out
module key_expansion
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [3:0]      rnd,
    input  logic [32*NK-1:0] win,
    output logic [32*NK-1:0] nxt
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which also maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        word_t prev;
        word_t t;
        word_t last;
        prev = '0;
        t    = '0;
        last = win[31:0];
        nxt  = '0;
        for (int i = 0; i < NK; i++) begin
            if (i == 0) begin
                t = sub_word({last[23:0], last[31:24]}) ^ {rcon(rnd), 24'h000000};
            end else if (NK == 8 && i == 4) begin
                t = sub_word(prev);
            end else begin
                t = prev;
            end
            prev = win[32*(NK-1-i) +: 32] ^ t;
            nxt[32*(NK-1-i) +: 32] = prev;
        end
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// rtl/aes_key_schedule_ctrl.sv - sequences key expansion one step per clock and serves 128-bit round keys
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*Nk-1:0]  key_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              key_valid,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_out
);

    localparam int NR    = nr_of(Nk);
    localparam int WORDS = words_of(Nk);
    localparam int STEPS = steps_of(Nk);

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic        key_valid_q, key_valid_d;
    word_t       w_q [WORDS];
    word_t       w_d [WORDS];

    logic [32*Nk-1:0] win;
    logic [32*Nk-1:0] nxt;

    // Window feeding the step unit is the Nk words produced by the previous step
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int i = 0; i < Nk; i++) begin
            idx = (int'(step_q) - 1) * Nk + i;
            if (idx >= 0 && idx < WORDS) win[32*(Nk-1-i) +: 32] = w_q[idx];
        end
    end

    key_expansion #(.NK(Nk)) u_step (
        .rnd (step_q),
        .win (win),
        .nxt (nxt)
    );

    always_comb begin
        int idx;
        idx         = 0;
        state_d     = state_q;
        step_d      = step_q;
        key_valid_d = key_valid_q;
        w_d         = w_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < Nk; i++) w_d[i] = key_in[32*(Nk-1-i) +: 32];
                    key_valid_d = 1'b0;
                    step_d      = 4'd1;
                    state_d     = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                // The last step for Nk=6/8 overruns the schedule; those words are dropped
                for (int i = 0; i < Nk; i++) begin
                    idx = int'(step_q) * Nk + i;
                    if (idx < WORDS) w_d[idx] = nxt[32*(Nk-1-i) +: 32];
                end
                if (step_q == 4'(STEPS)) begin
                    key_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_DONE: begin
                step_d  = 4'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    always_comb begin
        rk_out = '0;
        if (key_valid_q && int'(rk_idx) <= NR) begin
            for (int j = 0; j < 4; j++) rk_out[32*(3-j) +: 32] = w_q[4*int'(rk_idx) + j];
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_EXPAND);
    assign done      = (state_q == ST_DONE);
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb/tb_aes_key_schedule_ctrl.sv - self-checking bench for aes_key_schedule_ctrl with Nk=4, 6 and 8 instances
module tb_aes_key_schedule_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [127:0] key4 = '0;
    logic [191:0] key6 = '0;
    logic [255:0] key8 = '0;
    logic [3:0]   idx4 = '0, idx6 = '0, idx8 = '0;
    logic         rdy4, rdy6, rdy8, bsy4, bsy6, bsy8, dn4, dn6, dn8, kv4, kv6, kv8;
    logic [127:0] rk4, rk6, rk8;

    aes_key_schedule_ctrl #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
        .ready(rdy4), .busy(bsy4), .done(dn4), .key_valid(kv4), .rk_idx(idx4), .rk_out(rk4));
    aes_key_schedule_ctrl #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
        .ready(rdy6), .busy(bsy6), .done(dn6), .key_valid(kv6), .rk_idx(idx6), .rk_out(rk6));
    aes_key_schedule_ctrl #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .key_valid(kv8), .rk_idx(idx8), .rk_out(rk8));

    localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int tests = 0;
    int fails = 0;
    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from the generator-3 walk of GF(2^8) and its inverse walk
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Textbook word-by-word key expansion; key is right-aligned with word 0 highest
    task automatic model(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) mw[i] = key[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int nk, input int idx);
        if (idx > nk + 6) return '0;
        return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
    endfunction

    function automatic int exp_lat(input int nk);
        return (4 * (nk + 7) - nk + nk - 1) / nk + 1;
    endfunction

    function automatic logic sig_done(input int nk);
        case (nk)
            4: return dn4;
            6: return dn6;
            default: return dn8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int nk, input logic v, input logic [255:0] key);
        case (nk)
            4: begin start4 = v; key4 = key[127:0]; end
            6: begin start6 = v; key6 = key[191:0]; end
            default: begin start8 = v; key8 = key; end
        endcase
    endtask

    task automatic get_rk(input int nk, input int idx, output logic [127:0] v);
        case (nk)
            4: idx4 = 4'(idx);
            6: idx6 = 4'(idx);
            default: idx8 = 4'(idx);
        endcase
        #1;
        case (nk)
            4: v = rk4;
            6: v = rk6;
            default: v = rk8;
        endcase
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input int nk, input logic [255:0] key, output int lat);
        set_start(nk, 1'b1, key);
        tick();
        set_start(nk, 1'b0, rand_key());
        lat = 1;
        while (!sig_done(nk) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_all(input int nk, input string tag);
        logic [127:0] v;
        for (int i = 0; i <= nk + 7; i++) begin
            get_rk(nk, i, v);
            check($sformatf("%s rk%0d", tag, i), v, exp_rk(nk, i));
            tick();
        end
    endtask

    initial begin
        int lat, n, busyc, donec, rdyc, bad;
        logic [127:0] v;
        logic [255:0] key;
        int nks [3];
        nks = '{4, 6, 8};
        build_sbox();

        #2 rst_n = 1'b0;
        #1;
        check("reset ready", rdy4, 1'b1);
        check("reset busy", bsy4, 1'b0);
        check("reset done", dn4, 1'b0);
        check("reset key_valid", {kv4, kv6, kv8}, 3'b000);
        check("reset rk_out", rk4, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        run(4, {128'h0, K4}, lat);
        check("nk4 latency", lat, 11);
        check("nk4 key_valid at done", kv4, 1'b1);
        model(4, {128'h0, K4});
        get_rk(4, 1, v);  check("nk4 rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        get_rk(4, 10, v); check("nk4 rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        get_rk(4, 0, v);  check("nk4 rk0", v, K4);
        check_all(4, "nk4 a1");

        run(6, {64'h0, K6}, lat);
        check("nk6 latency", lat, 9);
        model(6, {64'h0, K6});
        get_rk(6, 12, v); check("nk6 rk12", v, 128'he98ba06f448c773c8ecc720401002202);
        get_rk(6, 13, v); check("nk6 rk13", v, '0);
        check_all(6, "nk6 a2");

        run(8, K8, lat);
        check("nk8 latency", lat, 8);
        model(8, K8);
        get_rk(8, 14, v); check("nk8 rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);
        check_all(8, "nk8 a3");

        for (int rep = 0; rep < 2; rep++) begin
            foreach (nks[k]) begin
                key = rand_key();
                run(nks[k], key, lat);
                check($sformatf("rand nk%0d latency", nks[k]), lat, exp_lat(nks[k]));
                model(nks[k], key);
                check_all(nks[k], $sformatf("rand nk%0d", nks[k]));
            end
        end

        key = rand_key();
        set_start(4, 1'b1, key);
        tick();
        busyc = 0; donec = 0; rdyc = 0; n = 0;
        while (bsy4 && n < 30) begin
            busyc++;
            if (rdy4) rdyc++;
            if (dn4) donec++;
            set_start(4, 1'b1, rand_key());
            tick();
            n++;
        end
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dn4) donec++;
            tick();
        end
        check("repulse busy cycles", busyc, 10);
        check("repulse done pulses", donec, 1);
        check("repulse ready during busy", rdyc, 0);
        model(4, key);
        check_all(4, "repulse");

        set_start(4, 1'b1, {128'h0, K4});
        tick();
        set_start(4, 1'b0, rand_key());
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset ready", rdy4, 1'b1);
        check("midreset busy", bsy4, 1'b0);
        check("midreset done", dn4, 1'b0);
        check("midreset key_valid", kv4, 1'b0);
        check("midreset rk_out", rk4, '0);
        #2 rst_n = 1'b1;
        tick();
        run(4, {128'h0, K4}, lat);
        check("post reset latency", lat, 11);
        model(4, {128'h0, K4});
        get_rk(4, 10, v); check("post reset rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_all(4, "post reset");

        check("key_valid before restart", kv4, 1'b1);
        key = rand_key();
        idx4 = 4'd0;
        set_start(4, 1'b1, key);
        tick();
        set_start(4, 1'b0, rand_key());
        check("restart key_valid drop", kv4, 1'b0);
        check("restart rk_out zero", rk4, '0);
        bad = 0; n = 0;
        while (!dn4 && n < 40) begin
            if (rk4 !== '0 || kv4 !== 1'b0) bad++;
            idx4 = 4'($urandom_range(0, 10));
            tick();
            n++;
        end
        check("restart rk_out zero during expand", bad, 0);
        check("restart latency", n + 1, 11);
        model(4, key);
        check_all(4, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
